axil_led_regs: RTL

- AXI4-Lite responder behind the PCIe BAR inside the base PCIe design. The host-side DMA/bridge master is the initiator.
- Gives the host read/write access to the board LEDs, a scratch register, a link-status view and free-running counters.
- Sits between the bridge's AXI-Lite master port and the top-level LED[7:0] pins.

---
 rtl/axil_led_regs.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/axil_led_regs.sv
// AXI4-Lite register block: ID, LEDs, link status, scratch, cycle counter and link-down counter.
// Build option AXIL_LED_HEARTBEAT_EN drives led[7] from CYCLES[26] instead of the LED register.
module axil_led_regs #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] ID_VALUE = 32'hA11C_0D13,
  parameter logic [7:0]  LED_RST  = 8'h00
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  input  logic              pcie_link_up,
  output logic [7:0]        led
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [7:0]        led_reg;
  logic [31:0]       scratch;
  logic [31:0]       cycles;
  logic [31:0]       linkdn;
  logic              link_q;
  logic              link_seen;

  // Only offsets 0x00-0x14 with nothing set above bit 4 are backed by a register.
  function automatic logic mapped(input logic [ADDR_W-1:0] a);
    return ((a >> 5) == '0) && (a[4:2] <= 3'd5);
  endfunction

  logic [31:0] rd_val;
  always_comb begin
    rd_val = '0;
    if (mapped(s_axil_araddr)) begin
      case (s_axil_araddr[4:2])
        3'd0:    rd_val = ID_VALUE;
        3'd1:    rd_val = {24'b0, led_reg};
        3'd2:    rd_val = {30'b0, link_seen, pcie_link_up};
        3'd3:    rd_val = scratch;
        3'd4:    rd_val = cycles;
        3'd5:    rd_val = linkdn;
        default: rd_val = '0;
      endcase
    end
  end

  logic        do_write;
  logic        wr_map;
  logic [2:0]  wr_idx;
  logic [31:0] wr_old;
  logic [31:0] wr_new;
  logic        link_fall;
  logic        linkdn_clr;

  assign do_write   = aw_held && w_held && !s_axil_bvalid;
  assign wr_map     = mapped(awaddr_q);
  assign wr_idx     = awaddr_q[4:2];
  assign wr_old     = (wr_idx == 3'd1) ? {24'b0, led_reg} : scratch;
  assign link_fall  = link_q && !pcie_link_up;
  assign linkdn_clr = do_write && wr_map && (wr_idx == 3'd5);

  always_comb begin
    wr_new = wr_old;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) wr_new[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil_araddr[1:0], awaddr_q[1:0]};

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      s_axil_awready <= 1'b1;
      s_axil_wready  <= 1'b1;
      s_axil_arready <= 1'b1;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= RESP_OKAY;
      s_axil_rdata   <= '0;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      led_reg        <= LED_RST;
      scratch        <= '0;
      cycles         <= '0;
      linkdn         <= '0;
      link_q         <= 1'b0;
      link_seen      <= 1'b0;
    end else begin
      cycles <= cycles + 32'd1;
      link_q <= pcie_link_up;
      if (pcie_link_up) link_seen <= 1'b1;

      // A clear coinciding with a new link-down event keeps that event.
      if (linkdn_clr)                      linkdn <= link_fall ? 32'd1 : 32'd0;
      else if (link_fall && linkdn != '1)  linkdn <= linkdn + 32'd1;

      if (s_axil_awvalid && s_axil_awready) begin
        awaddr_q       <= s_axil_awaddr;
        aw_held        <= 1'b1;
        s_axil_awready <= 1'b0;
      end
      if (s_axil_wvalid && s_axil_wready) begin
        wdata_q       <= s_axil_wdata;
        wstrb_q       <= s_axil_wstrb;
        w_held        <= 1'b1;
        s_axil_wready <= 1'b0;
      end
      if (do_write) begin
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_map ? RESP_OKAY : RESP_SLVERR;
        if (wr_map && wr_idx == 3'd1) led_reg <= wr_new[7:0];
        if (wr_map && wr_idx == 3'd3) scratch <= wr_new;
      end
      if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid  <= 1'b0;
        s_axil_awready <= 1'b1;
        s_axil_wready  <= 1'b1;
      end

      if (s_axil_arvalid && s_axil_arready) begin
        s_axil_rdata   <= rd_val;
        s_axil_rresp   <= mapped(s_axil_araddr) ? RESP_OKAY : RESP_SLVERR;
        s_axil_rvalid  <= 1'b1;
        s_axil_arready <= 1'b0;
      end
      if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid  <= 1'b0;
        s_axil_arready <= 1'b1;
      end
    end
  end

`ifdef AXIL_LED_HEARTBEAT_EN
  assign led = {cycles[26], led_reg[6:0]};
`else
  assign led = led_reg;
`endif

endmodule
